// File: rtl/hazard_stall_ctrl.sv
// Stall / flush / multdiv-interlock controller for the 5-stage pipeline.
// Resolves load-use hazards, wrong-path instructions after a taken
// branch/jump and multi-cycle mul/div by holding or killing stages.
module hazard_stall_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             branch_taken_x,
  input  logic             multdiv_rdy,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             flush_fd,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             multdiv_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] busy_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [4:0] w_fd_op, w_fd_rd, w_fd_rs1, w_fd_rs2;
  logic [4:0] w_dx_op, w_dx_rd, w_dx_alu;
  logic       w_fd_rd_src, w_fd_rs1_src, w_fd_rs2_src;
  logic       w_dx_mul, w_dx_div, w_load_use;
  logic       w_unused;

  // Field extraction for both latches
  assign w_fd_op  = fd_insn[31:27];
  assign w_fd_rd  = fd_insn[26:22];
  assign w_fd_rs1 = fd_insn[21:17];
  assign w_fd_rs2 = fd_insn[16:12];
  assign w_dx_op  = dx_insn[31:27];
  assign w_dx_rd  = dx_insn[26:22];
  assign w_dx_alu = dx_insn[6:2];
  assign w_unused = ^{fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};

  // Which fd fields are real source operands for this opcode
  assign w_fd_rd_src  = (w_fd_op == OP_SW) || (w_fd_op == OP_BNE) ||
                        (w_fd_op == OP_BLT) || (w_fd_op == OP_JR);
  assign w_fd_rs1_src = (w_fd_op == OP_RTYPE) || (w_fd_op == OP_ADDI) ||
                        (w_fd_op == OP_LW) || (w_fd_op == OP_SW) ||
                        (w_fd_op == OP_BNE) || (w_fd_op == OP_BLT);
  assign w_fd_rs2_src = (w_fd_op == OP_RTYPE);

  assign w_dx_mul = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_MUL);
  assign w_dx_div = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_DIV);

  // lw in X whose nonzero destination is read by the instruction in D
  assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                      ((w_fd_rd_src  && (w_fd_rd  == w_dx_rd)) ||
                       (w_fd_rs1_src && (w_fd_rs1 == w_dx_rd)) ||
                       (w_fd_rs2_src && (w_fd_rs2 == w_dx_rd)));

  // State and busy counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and pipeline controls; flush beats multdiv beats load-use
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    stall_pc     = 1'b0;
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    bubble_dx    = 1'b0;
    bubble_xm    = 1'b0;
    flush_fd     = 1'b0;
    ctrl_mult    = 1'b0;
    ctrl_div     = 1'b0;
    multdiv_busy = 1'b0;
    timeout_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (branch_taken_x) begin
          flush_fd  = 1'b1;
          bubble_dx = 1'b1;
        end else if (w_dx_mul || w_dx_div) begin
          ctrl_mult   = w_dx_mul;
          ctrl_div    = w_dx_div;
          stall_pc    = 1'b1;
          stall_fd    = 1'b1;
          stall_dx    = 1'b1;
          bubble_xm   = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = '0;
        end else if (w_load_use) begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      S_BUSY: begin
        multdiv_busy = 1'b1;
        if (multdiv_rdy || (r_cnt == CNT_LAST)) begin
          timeout_err = !multdiv_rdy;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          stall_pc  = 1'b1;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
          if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!reset) begin
      stall_pc     = 1'b0;
      stall_fd     = 1'b0;
      stall_dx     = 1'b0;
      bubble_dx    = 1'b0;
      bubble_xm    = 1'b0;
      flush_fd     = 1'b0;
      ctrl_mult    = 1'b0;
      ctrl_div     = 1'b0;
      multdiv_busy = 1'b0;
      timeout_err  = 1'b0;
    end
  end

  // Counter is visible only while out of reset
  assign busy_count = reset ? r_cnt : '0;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed test-plan scenarios
// followed by randomized traffic, all checked against a per-cycle model.
module tb_hazard_stall_ctrl;

  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic        clk = 1'b0;
  logic        reset, branch_taken_x, multdiv_rdy;
  logic [31:0] fd_insn, dx_insn;
  logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
  logic        ctrl_mult, ctrl_div, multdiv_busy, timeout_err;
  logic [CNT_W-1:0] busy_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  logic [15:0] exp_q[$];

  // Model state: whether a mul/div is outstanding and how long it has run
  bit m_busy = 0;
  int m_elapsed = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn),
    .branch_taken_x(branch_taken_x), .multdiv_rdy(multdiv_rdy),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .flush_fd(flush_fd),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .multdiv_busy(multdiv_busy),
    .timeout_err(timeout_err), .busy_count(busy_count)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] alu);
    return {op, rd, rs1, rs2, 5'd0, alu, 2'd0};
  endfunction

  // Does instruction 'insn' read architectural register r?
  function automatic bit reads(input logic [31:0] insn, input logic [4:0] r);
    logic [4:0] op, rd, rs1, rs2;
    op = insn[31:27]; rd = insn[26:22]; rs1 = insn[21:17]; rs2 = insn[16:12];
    if (r == 5'd0) return 0;
    case (op)
      5'b00000:                   return (rs1 == r) || (rs2 == r);
      5'b00101, 5'b01000:         return rs1 == r;
      5'b00111, 5'b00010, 5'b00110: return (rd == r) || (rs1 == r);
      5'b00100:                   return rd == r;
      default:                    return 0;
    endcase
  endfunction

  // Expected outputs this cycle, then advance the model across the edge
  function automatic logic [15:0] model(input bit rst_n, input logic [31:0] fd,
                                        input logic [31:0] dx, input bit br,
                                        input bit rdy);
    bit spc = 0, sfd = 0, sdx = 0, bdx = 0, bxm = 0, ffd = 0;
    bit cm = 0, cd = 0, bsy = 0, err = 0;
    int cnt = 0;
    bit is_mul, is_div, is_lu;
    is_mul = (dx[31:27] == 5'b00000) && (dx[6:2] == 5'd6);
    is_div = (dx[31:27] == 5'b00000) && (dx[6:2] == 5'd7);
    is_lu  = (dx[31:27] == 5'b01000) && reads(fd, dx[26:22]);
    if (!rst_n) begin
      m_busy = 0; m_elapsed = 0;
    end else if (m_busy) begin
      bsy = 1; cnt = m_elapsed;
      if (rdy || m_elapsed == TIMEOUT - 1) begin
        err = !rdy;
        m_busy = 0; m_elapsed = 0;
      end else begin
        spc = 1; sfd = 1; sdx = 1; bxm = 1;
        m_elapsed = (m_elapsed + 1 > TIMEOUT) ? TIMEOUT : m_elapsed + 1;
      end
    end else if (br) begin
      ffd = 1; bdx = 1;
    end else if (is_mul || is_div) begin
      cm = is_mul; cd = is_div;
      spc = 1; sfd = 1; sdx = 1; bxm = 1;
      m_busy = 1; m_elapsed = 0;
    end else if (is_lu) begin
      spc = 1; sfd = 1; bdx = 1;
    end
    return {spc, sfd, sdx, bdx, bxm, ffd, cm, cd, bsy, err, 6'(cnt)};
  endfunction

  task automatic cycle(input bit rst_n, input logic [31:0] fd, input logic [31:0] dx,
                       input bit br, input bit rdy);
    @(negedge clk);
    reset = rst_n; fd_insn = fd; dx_insn = dx; branch_taken_x = br; multdiv_rdy = rdy;
    #1;
    exp_q.push_back(model(rst_n, fd, dx, br, rdy));
  endtask

  // Monitor: the controls are valid every cycle once inputs settle
  initial begin
    logic [15:0] act, expv;
    forever begin
      @(negedge clk);
      #2;
      n_cyc++;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        act = {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
               ctrl_mult, ctrl_div, multdiv_busy, timeout_err, busy_count};
        n_tests++;
        if (act !== expv) begin
          n_fail++;
          $display("FAIL ctrl cyc=%0d {spc,sfd,sdx,bdx,bxm,ffd,cm,cd,busy,err,cnt} actual=%b_%0d required=%b_%0d",
                   n_cyc, act[15:6], act[5:0], expv[15:6], expv[5:0]);
        end
      end
    end
  end

  logic [31:0] nop, lw52, add657, lw0, add600, addi635, mul412, div412, sw52;
  logic [4:0] ops [8];

  initial begin
    nop     = mk(5'b00000, 5'd0, 5'd0, 5'd0, 5'd0);
    lw52    = mk(5'b01000, 5'd5, 5'd2, 5'd0, 5'd0);
    add657  = mk(5'b00000, 5'd6, 5'd5, 5'd7, 5'd0);
    lw0     = mk(5'b01000, 5'd0, 5'd2, 5'd0, 5'd0);
    add600  = mk(5'b00000, 5'd6, 5'd0, 5'd0, 5'd0);
    addi635 = mk(5'b00101, 5'd6, 5'd3, 5'd5, 5'd0);
    mul412  = mk(5'b00000, 5'd4, 5'd1, 5'd2, 5'd6);
    div412  = mk(5'b00000, 5'd4, 5'd1, 5'd2, 5'd7);
    sw52    = mk(5'b00111, 5'd5, 5'd2, 5'd0, 5'd0);
    ops = '{5'b00000, 5'b01000, 5'b00111, 5'b00101, 5'b00010, 5'b00110, 5'b00100, 5'b01111};

    // reset state
    repeat (2) cycle(0, add657, mul412, 1, 1);
    // load-use: one stall cycle, then lw has advanced
    cycle(1, add657, lw52, 0, 0);
    cycle(1, nop, add657, 0, 0);
    // zero register and addi's unused rs2 field
    cycle(1, add600, lw0, 0, 0);
    cycle(1, addi635, lw52, 0, 0);
    // multiply, ready three cycles after start
    cycle(1, nop, mul412, 0, 0);
    cycle(1, nop, mul412, 0, 0);
    cycle(1, nop, mul412, 0, 0);
    cycle(1, nop, mul412, 0, 1);
    cycle(1, nop, nop, 0, 1);
    // divide that never completes
    for (int i = 0; i < TIMEOUT + 1; i++) cycle(1, nop, div412, 0, 0);
    cycle(1, nop, nop, 0, 0);
    // flush wins over a present load-use
    cycle(1, sw52, lw52, 1, 0);
    // reset mid-BUSY at busy_count 10, then the same mul restarts
    for (int i = 0; i < 11; i++) cycle(1, nop, mul412, 0, 0);
    cycle(0, nop, mul412, 0, 0);
    cycle(1, nop, mul412, 0, 0);
    cycle(1, nop, mul412, 0, 1);
    cycle(1, nop, nop, 0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] f, d;
      logic [4:0] alu_sel [4];
      alu_sel = '{5'd0, 5'd3, 5'd6, 5'd7};
      f = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), alu_sel[$urandom_range(0, 3)]);
      d = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), alu_sel[$urandom_range(0, 3)]);
      cycle(($urandom_range(0, 99) != 0), f, d, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 15) == 0));
    end
    repeat (2) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
